// File: rtl/scpu_pkg.sv
// Shared types and constants for the memory bus arbiter: FSM states,
// requester ids and the default memory latency.
package scpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    localparam logic REQ_CU  = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam int unsigned MEM_LAT_DEFAULT = 1;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Two-way priority picker: the requester named by pointer wins a tie,
// a lone requester always wins.
module rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic pointer,
    output logic valid,
    output logic id
);

    assign valid = req0 | req1;
    assign id    = (req0 & req1) ? pointer : req1;

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester memory bus arbiter with a SETUP/ACCESS/DONE transaction FSM.
// Define ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead of round robin.
module bus_arbiter
    import scpu_pkg::*;
#(
    parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        ack0,
    output logic        ack1,
    output logic [7:0]  rdata,
    output logic        mem_ce,
    output logic        mem_r,
    output logic        mem_w,
    output logic        mem_oe,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        busy
);

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        win;
    logic        lat_we;
    logic [15:0] lat_addr;
    logic [7:0]  lat_wdata;
    logic [7:0]  rdata_q;
    logic        pick_valid;
    logic        pick_id;

`ifdef ARB_FIXED_PRIO_EN
    assign pick_valid = req0 | req1;
    assign pick_id    = req0 ? REQ_CU : REQ_DBG;
`else
    logic pointer;

    rr_pick u_pick (
        .req0    (req0),
        .req1    (req1),
        .pointer (pointer),
        .valid   (pick_valid),
        .id      (pick_id)
    );

    always_ff @(posedge clk) begin
        if (rst)
            pointer <= REQ_CU;
        else if (state == IDLE && pick_valid)
            pointer <= ~pick_id;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Requester inputs are only looked at in IDLE; everything after runs off the latched copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            win       <= REQ_CU;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        win       <= pick_id;
                        lat_we    <= pick_id ? we1    : we0;
                        lat_addr  <= pick_id ? addr1  : addr0;
                        lat_wdata <= pick_id ? wdata1 : wdata0;
                    end
                end
                SETUP: cnt <= LAT_LOAD;
                ACCESS: begin
                    if (cnt != '0)
                        cnt <= cnt - 4'd1;
                    else if (!lat_we)
                        rdata_q <= mem_rdata;
                end
                DONE: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        mem_ce    = 1'b0;
        mem_r     = 1'b0;
        mem_w     = 1'b0;
        mem_oe    = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (pick_valid)
                    state_nxt = SETUP;
            end
            SETUP: begin
                gnt0      = (win == REQ_CU);
                gnt1      = (win == REQ_DBG);
                mem_ce    = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                gnt0   = (win == REQ_CU);
                gnt1   = (win == REQ_DBG);
                mem_ce = 1'b1;
                mem_r  = ~lat_we;
                mem_oe = ~lat_we;
                mem_w  = lat_we;
                if (cnt == '0)
                    state_nxt = DONE;
            end
            DONE: begin
                gnt0      = (win == REQ_CU);
                gnt1      = (win == REQ_DBG);
                ack0      = (win == REQ_CU);
                ack1      = (win == REQ_DBG);
                state_nxt = IDLE;
            end
        endcase
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign rdata     = rdata_q;

endmodule
